mem_write_ctrl: RTL and testbench
=================================

MEM_WRITE_CTRL -- requirements
Module: mem_write_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 20000: number of stable cycles required for press and release debounce (legal range ≥2).
REQ-002 Parameter SCAN_DIV, default 1000000: number of CLK cycles per playback address step (legal range ≥2).
REQ-003 CLK  input  1  the single system clock; all state updates on its rising edge.
REQ-004 RSTN  input  1  reset, asynchronous, active-low.
REQ-005 KEY_IN  input  10  raw digit switches, active-high; bit n means digit n.
REQ-006 MODE  input  1  asynchronous level: 0 = entry (write), 1 = playback (read scan).
REQ-007 CLR  input  1  synchronous clear request, sampled each cycle.
REQ-008 WR  output  1  one-cycle write strobe to the 16x4 digit store.
REQ-009 RD  output  1  read enable to the digit store.
REQ-010 mem_addr  output  4  store address.
REQ-011 D_OUT  output  10  one-hot digit presented with WR.
REQ-012 WR_CNT  output  5  count of valid stored entries, 0..16.
REQ-013 BUSY  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 The block SHALL pass KEY_IN and MODE through 2-flop synchronizers; all logic uses the synchronized copies (2-cycle input latency). CLR is not synchronized.
REQ-015 A synchronized key vector SHALL count as valid only if exactly one bit is set; all-zero and multi-hot vectors are "no key".
REQ-016 The FSM SHALL have exactly four states: IDLE, DEBOUNCE, WRITE, RELEASE.
REQ-017 IDLE -> DEBOUNCE when MODE=0 and the key vector is valid; the block latches the vector and clears the debounce counter.
REQ-018 DEBOUNCE -> IDLE when the key vector differs from the latch or MODE=1 (no write); DEBOUNCE -> WRITE after DEB_CYCLES consecutive matching cycles.
REQ-019 WRITE SHALL last exactly one cycle with WR=1, D_OUT=latch and mem_addr=wptr, then go to RELEASE; a MODE change during WRITE does not abort it.
REQ-020 On the cycle after WRITE, wptr SHALL increment modulo 16 (15 wraps to 0), and WR_CNT SHALL increment, saturating at 16.
REQ-021 RELEASE -> IDLE after DEB_CYCLES consecutive all-zero key cycles; any nonzero vector restarts that count. A held key therefore never produces a second write.
REQ-022 D_OUT SHALL be 0 and WR SHALL be 0 in every state except WRITE.
REQ-023 In entry mode, RD=0 and mem_addr=wptr.
REQ-024 In playback mode, when WR_CNT>0:
  - RD=1 and mem_addr=rptr.
  - rptr advances every SCAN_DIV cycles.
  - rptr wraps to 0 after reaching WR_CNT-1.
REQ-025 In playback mode with WR_CNT=0, RD=0 and mem_addr=0.
REQ-026 On each 0->1 transition of the synchronized MODE, rptr and the scan timer SHALL clear to 0.
REQ-027 CLR=1 SHALL clear wptr, rptr, WR_CNT and the scan timer and force IDLE on the next edge. CLR in the same cycle as WRITE suppresses the pointer/count update; WR is still issued for that cycle.
REQ-028 BUSY SHALL equal (state != IDLE).

Reset
REQ-029 While RSTN=0 the block SHALL immediately force the following, independent of CLK:
  - state = IDLE.
  - WR, RD, mem_addr, D_OUT, WR_CNT, BUSY = 0.
  - wptr, rptr, latch, all counters and synchronizers = 0.
REQ-030 Reset asserted mid-debounce or mid-WRITE SHALL abandon the operation; no WR is issued after reset deasserts until a fresh debounced press occurs.

Verification (DEB_CYCLES=4, SCAN_DIV=8)
REQ-031 Hold KEY_IN=10'b0000001000 for 10 cycles in MODE=0 -> exactly one WR pulse with D_OUT=10'b0000001000 and mem_addr=0; then WR_CNT=1 and wptr=1.
REQ-032 Glitch KEY_IN=bit5 for 2 cycles, then KEY_IN=bits 2 and 3 together for 10 cycles -> no WR, WR_CNT stays 0, BUSY returns to 0.
REQ-033 Perform 17 debounced presses -> the 17th write goes to mem_addr=0 and WR_CNT stays 16.
REQ-034 Store 3 digits, set MODE=1 -> RD=1, mem_addr sequence 0,1,2,0 with each value held for 8 cycles.
REQ-035 Assert CLR in the WRITE cycle -> WR pulse occurs, then wptr=0 and WR_CNT=0; in MODE=1 afterwards RD stays 0.
REQ-036 Drop RSTN during DEBOUNCE -> all outputs 0 immediately; release RSTN with the key still held -> a WR occurs only after a full new debounce.

Source files
------------

// File: rtl/mem_write_ctrl.sv
// Debounced digit-entry controller for a 16x4 digit store.
// Entry mode writes one-hot digits; playback mode scans the stored entries.
module mem_write_ctrl #(
    parameter int DEB_CYCLES = 20000,
    parameter int SCAN_DIV   = 1000000
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic [9:0] KEY_IN,
    input  logic       MODE,
    input  logic       CLR,
    output logic       WR,
    output logic       RD,
    output logic [3:0] mem_addr,
    output logic [9:0] D_OUT,
    output logic [4:0] WR_CNT,
    output logic       BUSY
);

    localparam int DW = $clog2(DEB_CYCLES);
    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        WRITE    = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    function automatic logic is_onehot(input logic [9:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 10; i++) begin
            n = n + {3'd0, v[i]};
        end
        return (n == 4'd1);
    endfunction

    state_t        state_q;
    logic [9:0]    key_s1_q, key_s2_q;
    logic          mode_s1_q, mode_s2_q;
    logic [9:0]    latch_q;
    logic [DW-1:0] deb_q;
    logic          wr_q;
    logic [9:0]    dout_q;
    logic [3:0]    wptr_q, wptr_d;
    logic [3:0]    rptr_q, rptr_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [SW-1:0] scan_q, scan_d;

    logic key_valid_s;
    logic mode_rise_s;
    logic playback_s;

    assign key_valid_s = is_onehot(key_s2_q);
    // Fires on the edge where the synchronized mode copy goes 0->1.
    assign mode_rise_s = mode_s1_q & ~mode_s2_q;

    // Two-flop synchronizers for the switch and mode inputs.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            key_s1_q  <= 10'd0;
            key_s2_q  <= 10'd0;
            mode_s1_q <= 1'b0;
            mode_s2_q <= 1'b0;
        end else begin
            key_s1_q  <= KEY_IN;
            key_s2_q  <= key_s1_q;
            mode_s1_q <= MODE;
            mode_s2_q <= mode_s1_q;
        end
    end

    // Entry FSM with registered write strobe and digit output.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            latch_q <= 10'd0;
            deb_q   <= '0;
            wr_q    <= 1'b0;
            dout_q  <= 10'd0;
        end else if (CLR) begin
            state_q <= IDLE;
            deb_q   <= '0;
            wr_q    <= 1'b0;
            dout_q  <= 10'd0;
        end else begin
            wr_q   <= 1'b0;
            dout_q <= 10'd0;
            case (state_q)
                IDLE: begin
                    if (!mode_s2_q && key_valid_s) begin
                        state_q <= DEBOUNCE;
                        latch_q <= key_s2_q;
                        deb_q   <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                DEBOUNCE: begin
                    if ((key_s2_q != latch_q) || mode_s2_q) begin
                        state_q <= IDLE;
                    end else if (deb_q == DEB_LAST) begin
                        state_q <= WRITE;
                        wr_q    <= 1'b1;
                        dout_q  <= latch_q;
                    end else begin
                        deb_q <= deb_q + DW'(1);
                    end
                end
                WRITE: begin
                    state_q <= RELEASE;
                    deb_q   <= '0;
                end
                RELEASE: begin
                    // Any activity restarts the release window so a held key cannot re-trigger.
                    if (key_s2_q != 10'd0) begin
                        deb_q <= '0;
                    end else if (deb_q == DEB_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        deb_q <= deb_q + DW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Next-state logic for write/read pointers, entry count and scan timer.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        scan_d = scan_q;
        if (CLR) begin
            wptr_d = 4'd0;
            rptr_d = 4'd0;
            cnt_d  = 5'd0;
            scan_d = '0;
        end else begin
            if (state_q == WRITE) begin
                wptr_d = wptr_q + 4'd1;
                cnt_d  = (cnt_q == 5'd16) ? cnt_q : cnt_q + 5'd1;
            end else begin
                wptr_d = wptr_q;
            end
            if (mode_rise_s) begin
                rptr_d = 4'd0;
                scan_d = '0;
            end else if (mode_s2_q && (cnt_q != 5'd0)) begin
                if (scan_q == SCAN_LAST) begin
                    scan_d = '0;
                    rptr_d = (({1'b0, rptr_q} + 5'd1) >= cnt_q) ? 4'd0 : rptr_q + 4'd1;
                end else begin
                    scan_d = scan_q + SW'(1);
                end
            end else begin
                scan_d = scan_q;
            end
        end
    end

    // Pointer, count and scan-timer registers.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wptr_q <= 4'd0;
            rptr_q <= 4'd0;
            cnt_q  <= 5'd0;
            scan_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            scan_q <= scan_d;
        end
    end

    // A write in progress keeps the address on wptr even if mode flips.
    assign playback_s = mode_s2_q && (state_q != WRITE);

    assign WR       = wr_q;
    assign D_OUT    = dout_q;
    assign WR_CNT   = cnt_q;
    assign BUSY     = (state_q != IDLE);
    assign RD       = playback_s && (cnt_q != 5'd0);
    assign mem_addr = !playback_s ? wptr_q : ((cnt_q != 5'd0) ? rptr_q : 4'd0);

endmodule

// File: tb/tb_mem_write_ctrl.sv
// Directed bench for mem_write_ctrl with DEB_CYCLES=4 and SCAN_DIV=8.
module tb_mem_write_ctrl;

    logic       CLK;
    logic       RSTN;
    logic [9:0] KEY_IN;
    logic       MODE;
    logic       CLR;
    logic       WR;
    logic       RD;
    logic [3:0] mem_addr;
    logic [9:0] D_OUT;
    logic [4:0] WR_CNT;
    logic       BUSY;

    int err_cnt;
    int chk_cnt;
    int wr_total;
    int base;
    logic [3:0] last_addr;
    logic [9:0] last_data;

    mem_write_ctrl #(.DEB_CYCLES(4), .SCAN_DIV(8)) dut (
        .CLK(CLK), .RSTN(RSTN), .KEY_IN(KEY_IN), .MODE(MODE), .CLR(CLR),
        .WR(WR), .RD(RD), .mem_addr(mem_addr), .D_OUT(D_OUT),
        .WR_CNT(WR_CNT), .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Records every write strobe seen on the falling edge.
    always @(negedge CLK) begin
        if (WR) begin
            wr_total  <= wr_total + 1;
            last_addr <= mem_addr;
            last_data <= D_OUT;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RSTN = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RSTN = 1'b1;
        tick();
    endtask

    task automatic press(input logic [9:0] v);
        KEY_IN = v;
        repeat (10) tick();
        KEY_IN = 10'd0;
        repeat (10) tick();
    endtask

    initial begin
        err_cnt   = 0;
        chk_cnt   = 0;
        wr_total  = 0;
        last_addr = 4'd0;
        last_data = 10'd0;
        KEY_IN    = 10'd0;
        MODE      = 1'b0;
        CLR       = 1'b0;
        RSTN      = 1'b0;
        #2;
        check("rst_wr", WR, 0);
        check("rst_rd", RD, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_dout", D_OUT, 0);
        check("rst_cnt", WR_CNT, 0);
        check("rst_busy", BUSY, 0);
        do_reset();

        // Single held key: write lands exactly 7 edges after the key appears.
        base = wr_total;
        KEY_IN = 10'b0000001000;
        repeat (6) tick();
        check("t1_no_early_wr", WR, 0);
        check("t1_busy_deb", BUSY, 1);
        tick();
        check("t1_wr", WR, 1);
        check("t1_dout", D_OUT, 10'b0000001000);
        check("t1_addr", mem_addr, 0);
        tick();
        check("t1_wr_low", WR, 0);
        check("t1_dout_low", D_OUT, 0);
        check("t1_cnt", WR_CNT, 1);
        check("t1_wptr", mem_addr, 1);
        repeat (2) tick();
        KEY_IN = 10'd0;
        repeat (5) tick();
        check("t1_busy_release", BUSY, 1);
        tick();
        check("t1_busy_idle", BUSY, 0);
        repeat (4) tick();
        check("t1_one_pulse", wr_total - base, 1);

        // Short glitch then a multi-hot chord: no write.
        do_reset();
        base = wr_total;
        KEY_IN = 10'b0000100000;
        repeat (2) tick();
        KEY_IN = 10'b0000001100;
        tick();
        check("t2_busy_glitch", BUSY, 1);
        repeat (9) tick();
        KEY_IN = 10'd0;
        repeat (10) tick();
        check("t2_no_wr", wr_total - base, 0);
        check("t2_cnt", WR_CNT, 0);
        check("t2_busy", BUSY, 0);

        // Seventeen presses: pointer wraps, count saturates.
        do_reset();
        base = wr_total;
        for (int i = 0; i < 16; i++) begin
            press(10'd1 << (i % 10));
        end
        check("t3_last16_addr", last_addr, 15);
        check("t3_cnt16", WR_CNT, 16);
        check("t3_wptr_wrap", mem_addr, 0);
        press(10'b1000000000);
        check("t3_17_addr", last_addr, 0);
        check("t3_17_data", last_data, 10'b1000000000);
        check("t3_cnt_sat", WR_CNT, 16);
        check("t3_pulses", wr_total - base, 17);

        // Three digits then playback scan 0,1,2,0 each held 8 cycles.
        do_reset();
        press(10'b0000000010);
        press(10'b0000010000);
        press(10'b0010000000);
        check("t4_cnt", WR_CNT, 3);
        MODE = 1'b1;
        tick();
        check("t4_rd_pre", RD, 0);
        check("t4_addr_pre", mem_addr, 3);
        tick();
        for (int k = 0; k < 32; k++) begin
            check($sformatf("t4_addr_%0d", k), mem_addr, (k / 8) % 3);
            check($sformatf("t4_rd_%0d", k), RD, 1);
            tick();
        end
        MODE = 1'b0;
        repeat (3) tick();

        // Clear during the WRITE cycle.
        do_reset();
        base = wr_total;
        KEY_IN = 10'b0000000001;
        repeat (6) tick();
        KEY_IN = 10'd0;
        tick();
        check("t5_wr", WR, 1);
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        check("t5_wr_low", WR, 0);
        check("t5_cnt", WR_CNT, 0);
        check("t5_wptr", mem_addr, 0);
        check("t5_busy", BUSY, 0);
        MODE = 1'b1;
        repeat (12) tick();
        check("t5_rd", RD, 0);
        check("t5_addr_pb", mem_addr, 0);
        check("t5_pulses", wr_total - base, 1);
        MODE = 1'b0;
        repeat (3) tick();

        // Reset mid-debounce, then a full new debounce with the key still held.
        do_reset();
        press(10'b0000000100);
        base = wr_total;
        KEY_IN = 10'b1000000000;
        repeat (4) tick();
        check("t6_busy_deb", BUSY, 1);
        RSTN = 1'b0;
        #2;
        check("t6_busy", BUSY, 0);
        check("t6_cnt", WR_CNT, 0);
        check("t6_addr", mem_addr, 0);
        check("t6_wr", WR, 0);
        check("t6_dout", D_OUT, 0);
        check("t6_rd", RD, 0);
        @(negedge CLK);
        RSTN = 1'b1;
        repeat (6) tick();
        check("t6_no_early_wr", wr_total - base, 0);
        tick();
        check("t6_wr", WR, 1);
        check("t6_wr_data", D_OUT, 10'b1000000000);
        check("t6_wr_addr", mem_addr, 0);
        KEY_IN = 10'd0;
        repeat (10) tick();
        check("t6_pulses", wr_total - base, 1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
